// File: rtl/face_detect_udiv_25ns_10ns_16_seq.sv
// Radix-2 restoring divider: 25-bit dividend / 10-bit divisor -> 16-bit quotient, 10-bit remainder.
// One quotient bit per enabled cycle, valid/ready on both sides, clock-enable freezes everything.
module face_detect_udiv_25ns_10ns_16_seq #(
    parameter int unsigned DIVIDEND_W = 25,
    parameter int unsigned DIVISOR_W  = 10,
    parameter int unsigned QUOT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ce,
    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [QUOT_W-1:0]     quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  err
);

    localparam int unsigned HiW  = DIVIDEND_W - QUOT_W;
    localparam int unsigned CntW = $clog2(QUOT_W);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e                state_q, state_d;
    logic [DIVISOR_W-1:0]  part_q, part_d;
    logic [QUOT_W-1:0]     shift_q, shift_d;
    logic [DIVISOR_W-1:0]  dvsr_q, dvsr_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [QUOT_W-1:0]     quot_q, quot_d;
    logic [DIVISOR_W-1:0]  rem_q, rem_d;
    logic                  err_q, err_d;

    logic                  in_xfer, out_xfer, in_err, q_bit;
    logic [DIVISOR_W-1:0]  dd_hi;
    logic [DIVISOR_W:0]    trial;
    logic [DIVISOR_W-1:0]  diff;

    assign dd_hi   = {{(DIVISOR_W-HiW){1'b0}}, dividend[DIVIDEND_W-1 -: HiW]};
    // A zero divisor also trips the overflow compare, but keep it explicit.
    assign in_err  = (divisor == '0) || (dd_hi >= divisor);
    assign in_xfer = ce && din_valid && din_ready;
    assign out_xfer = ce && dout_valid && dout_ready;

    // Partial remainder stays below the divisor, so the low bits of the difference are exact.
    assign trial = {part_q, shift_q[QUOT_W-1]};
    assign q_bit = (trial >= {1'b0, dvsr_q});
    assign diff  = trial[DIVISOR_W-1:0] - dvsr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            part_q  <= '0;
            shift_q <= '0;
            dvsr_q  <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            part_q  <= part_d;
            shift_q <= shift_d;
            dvsr_q  <= dvsr_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        part_d  = part_q;
        shift_d = shift_q;
        dvsr_d  = dvsr_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        err_d   = err_q;
        if (ce) begin
            unique case (state_q)
                StIdle: ;
                StCalc: begin
                    part_d  = q_bit ? diff : trial[DIVISOR_W-1:0];
                    shift_d = {shift_q[QUOT_W-2:0], q_bit};
                    if (cnt_q == '0) begin
                        state_d = StDone;
                        quot_d  = shift_d;
                        rem_d   = part_d;
                        err_d   = 1'b0;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                StDone: begin
                    if (out_xfer) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
            // A new operation overrides the drain to idle when both happen together.
            if (in_xfer) begin
                if (in_err) begin
                    state_d = StDone;
                    quot_d  = '1;
                    rem_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    state_d = StCalc;
                    part_d  = dd_hi;
                    shift_d = dividend[QUOT_W-1:0];
                    dvsr_d  = divisor;
                    cnt_d   = CntW'(QUOT_W - 1);
                end
            end
        end
    end

    always_comb begin
        din_ready  = 1'b0;
        dout_valid = 1'b0;
        unique case (state_q)
            StIdle: din_ready = 1'b1;
            StDone: begin
                dout_valid = 1'b1;
                din_ready  = dout_ready;
            end
            default: ;
        endcase
    end

    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign err       = err_q;

endmodule

// File: tb/tb_face_detect_udiv_25ns_10ns_16_seq.sv
// Bench for the sequential divider: directed literal cases plus randomized traffic
// checked every cycle against an arithmetic model with a latency countdown.
module tb_face_detect_udiv_25ns_10ns_16_seq;

    logic        clk = 1'b0;
    logic        rst_n, ce, din_valid, din_ready, dout_valid, dout_ready, err;
    logic [24:0] dividend;
    logic [9:0]  divisor;
    logic [15:0] quotient;
    logic [9:0]  remainder;

    always #5 clk = ~clk;

    face_detect_udiv_25ns_10ns_16_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ce         (ce),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .err        (err)
    );

    int     n_cmp = 0;
    int     n_bad = 0;
    // Model: 0 = idle, 1 = computing (m_left enabled edges to go), 2 = result held.
    int     m_st = 0;
    int     m_left = 0;
    longint m_dd = 0, m_dv = 0, e_q = 0, e_r = 0;
    logic   e_e = 1'b0;
    logic   last_acc = 1'b0;
    int     edge_no = 0;
    int     acc_edges[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_load(input longint dd, input longint dv);
        m_dd = dd;
        m_dv = dv;
        if (dv == 0 || dd / dv > 65535) begin
            e_q = 65535; e_r = 0; e_e = 1'b1; m_st = 2;
        end else begin
            e_q = dd / dv; e_r = dd % dv; e_e = 1'b0; m_st = 1; m_left = 16;
        end
    endtask

    // One clock: drive at negedge, check din_ready, advance model, check outputs after the edge.
    task automatic cycle(input logic v, input logic [24:0] dd, input logic [9:0] dv,
                         input logic rdy, input logic c, input logic rn);
        logic exp_rdy, acc, del;
        @(negedge clk);
        din_valid = v; dividend = dd; divisor = dv; dout_ready = rdy; ce = c; rst_n = rn;
        #1;
        exp_rdy = (m_st == 0) || (m_st == 2 && rdy);
        chk("din_ready", din_ready, exp_rdy);
        acc = rn && c && v && exp_rdy;
        del = rn && c && (m_st == 2) && rdy;
        if (!rn) begin
            m_st = 0;
        end else if (c) begin
            if (m_st == 1) begin
                m_left--;
                if (m_left == 0) m_st = 2;
            end else if (del) begin
                m_st = 0;
            end
            if (acc) model_load(longint'(dd), longint'(dv));
        end
        last_acc = acc;
        @(posedge clk);
        edge_no++;
        if (acc) acc_edges.push_back(edge_no);
        #1;
        chk("dout_valid", dout_valid, m_st == 2);
        if (!rn) begin
            chk("rst quotient", quotient, 0);
            chk("rst remainder", remainder, 0);
            chk("rst err", err, 0);
        end else if (m_st == 2) begin
            chk("quotient", quotient, e_q);
            chk("remainder", remainder, e_r);
            chk("err", err, e_e);
            if (!err) chk("q*d+r", longint'(quotient) * m_dv + longint'(remainder), m_dd);
        end
    endtask

    task automatic run_op(input longint dd, input longint dv, input longint eq, input longint er,
                          input logic ee, input int elat, input int stalls);
        int n, g, sp0, sp1, sp2;
        logic c;
        g = 0;
        do begin
            cycle(1'b1, 25'(dd), 10'(dv), 1'b1, 1'b1, 1'b1);
            g++;
        end while (!last_acc && g < 50);
        chk("accept", last_acc, 1);
        if (!last_acc) return;
        sp0 = $urandom_range(1, 5);
        sp1 = sp0 + $urandom_range(1, 4);
        sp2 = sp1 + $urandom_range(1, 4);
        n = 0;
        while (!dout_valid && n < 60) begin
            n++;
            c = !(stalls > 0 && (n == sp0 || n == sp1 || n == sp2));
            cycle(1'b0, '0, '0, 1'b0, c, 1'b1);
        end
        chk("latency", n, elat);
        chk("lit quotient", quotient, eq);
        chk("lit remainder", remainder, er);
        chk("lit err", err, ee);
        repeat (5) cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        chk("held quotient", quotient, eq);
        chk("held remainder", remainder, er);
        cycle(1'b0, '0, '0, 1'b1, 1'b1, 1'b1);
        chk("drained", dout_valid, 0);
    endtask

    initial begin
        longint dd, dv;
        int     k, g;
        rst_n = 1'b0; ce = 1'b0; din_valid = 1'b0; dout_ready = 1'b0;
        dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset dout_valid", dout_valid, 0);
        chk("reset quotient", quotient, 0);
        chk("reset remainder", remainder, 0);
        chk("reset err", err, 0);
        chk("reset din_ready", din_ready, 1);

        run_op(100, 7, 14, 2, 1'b0, 16, 0);
        run_op(1000000, 1000, 1000, 0, 1'b0, 16, 0);
        run_op(33554431, 1023, 32800, 31, 1'b0, 16, 0);
        run_op(65535, 1, 65535, 0, 1'b0, 16, 0);
        run_op(12345, 0, 65535, 0, 1'b1, 0, 0);
        run_op(65536, 1, 65535, 0, 1'b1, 0, 0);
        run_op(100, 7, 14, 2, 1'b0, 19, 3);

        // Back-to-back: one accept every 17 edges.
        acc_edges.delete();
        repeat (40) cycle(1'b1, 25'd100, 10'd7, 1'b1, 1'b1, 1'b1);
        chk("b2b count", acc_edges.size() >= 3, 1);
        for (int i = 1; i < acc_edges.size(); i++)
            chk("b2b period", acc_edges[i] - acc_edges[i-1], 17);
        g = 0;
        while (m_st != 0 && g < 30) begin
            cycle(1'b0, '0, '0, 1'b1, 1'b1, 1'b1);
            g++;
        end

        // Reset in the middle of an iteration.
        cycle(1'b1, 25'd100, 10'd7, 1'b1, 1'b1, 1'b1);
        repeat (8) cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        chk("mid rst dout_valid", dout_valid, 0);
        chk("mid rst quotient", quotient, 0);
        chk("mid rst din_ready", din_ready, 1);
        run_op(100, 7, 14, 2, 1'b0, 16, 0);

        for (int i = 0; i < 30000; i++) begin
            k = $urandom_range(0, 9);
            if (k == 0) dv = 0;
            else if (k < 4) dv = $urandom_range(1, 15);
            else dv = $urandom_range(1, 1023);
            if ($urandom_range(0, 1) == 0 || dv == 0) dd = longint'($urandom) & 64'h1FFFFFF;
            else dd = longint'($urandom) % (dv * 65536);
            cycle($urandom_range(0, 3) != 0, 25'(dd), 10'(dv), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 7) != 0, $urandom_range(0, 999) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
